oai22_exerciser: RTL and testbench
==================================

# oai22_exerciser

Sequential stimulus driver and response checker for a 4-input OAI22 cell under test in the power-characterisation harness. It walks the full 16-entry input space in binary or Gray order and drives IN1..IN4. It samples the cell's QN, compares it against the OAI22 truth function, and counts mismatches and QN toggles. It sits on the input/output pins of the gate under test and is its opposite end, generating what the cell receives and checking what the cell produces.

## Interface
- NUM_PASSES, 4: full 16-vector sweeps per run (1..255)
- SETTLE_CYC, 1: cycles a vector is held before sampling (0..15)
- CLK  input  1  sole clock, rising edge
- RSTB  input  1  asynchronous, active-low reset
- START  input  1  one-cycle run request, honoured only in IDLE or DONE
- MODE  input  1  0 = binary order, 1 = Gray order; captured on accepted START
- IN1, IN2, IN3, IN4  output  1 each  registered stimulus; vector v = {IN1,IN2,IN3,IN4}, IN4 = LSB
- QN  input  1  response from cell under test
- BUSY  output  1  high from the cycle after accepted START until DONE entered
- DONE  output  1  high in DONE state, held until next accepted START
- FAIL  output  1  ERR_CNT != 0, valid while DONE
- ERR_CNT  output  8  mismatch count, saturating at 255
- TOG_CNT  output  16  QN sample-to-sample changes, saturating at 65535

## Operation
- Expected response: exp = ~((IN1|IN2)&(IN3|IN4)), computed from the registered vector.
- States: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE); DONE -> SETTLE on START.
- Accepted START clears ERR_CNT and TOG_CNT and the previous-sample valid flag, latches MODE, and loads sequence index 0 (v = 0 in both modes). It also enters SETTLE with the settle counter set to SETTLE_CYC.
- SETTLE: count down. At 0, go to SAMPLE (SETTLE_CYC = 0 means SAMPLE directly).
- SAMPLE: compare QN with exp. ERR_CNT += 1 on mismatch. If the previous sample is valid and QN differs from it, TOG_CNT += 1. Store QN as the previous sample and set valid. Advance the index (wrap 15 -> 0, increment pass count on wrap). After the last vector of pass NUM_PASSES, go to DONE; otherwise drive the next vector and go to SETTLE.
- Gray mode: v = idx ^ (idx >> 1).
- The previous-sample value carries across pass boundaries, so the boundary transition counts as a toggle.
- START while BUSY is ignored. START in DONE restarts a run.
- RSTB low at any time, including mid-run: state IDLE, IN1..IN4 = 0, BUSY = DONE = FAIL = 0, counters 0, and all internal registers cleared.

## Timing
- Reset values: every output 0.
- Vector hold per step is SETTLE_CYC + 1 cycles. A run lasts 16 × NUM_PASSES × (SETTLE_CYC + 1) cycles from the first SETTLE cycle to DONE.
- Outputs change only on the rising CLK edge. IN1..IN4 update on the edge leaving SAMPLE.
- ERR_CNT and TOG_CNT update on the edge leaving SAMPLE and are final when DONE rises.
- QN is sampled only in SAMPLE. QN values in other states are don't-care.

## Structure
- Package oai22_ex_pkg holds the state enum (IDLE, SETTLE, SAMPLE, DONE), the function oai22_exp(v[3:0]), and the counter width constants.
- Sub-module oai22_seq_gen implements the 4-bit index, pass counter, binary/Gray mapping, and last-vector flag. The top level holds the FSM, settle counter, and checker.

## Test plan
- Golden cell, MODE=0, defaults -> DONE after 128 cycles, ERR_CNT=0, TOG_CNT=23 (5 per pass + 3 boundaries), FAIL=0.
- Golden cell, MODE=1, defaults -> ERR_CNT=0, TOG_CNT=16, vector order 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8 on IN1..IN4.
- QN tied 1, MODE=0, defaults -> ERR_CNT=36, TOG_CNT=0, FAIL=1.
- QN tied 1, NUM_PASSES=32 -> ERR_CNT saturates at 255, FAIL=1.
- RSTB pulsed low mid-run (vector 7, pass 2) -> all outputs 0 immediately. A subsequent START produces a clean run with the golden counts.
- START re-pulsed while BUSY -> ignored, counts unchanged. START in DONE -> counters clear and DONE drops on the next edge.

Source files
------------

// File: rtl/oai22_ex_pkg.sv
// oai22_ex_pkg: shared state encoding, counter widths and OAI22 reference function
package oai22_ex_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
    localparam int ERR_W = 8;
    localparam int TOG_W = 16;
    localparam int PASS_W = 8;
    function automatic logic oai22_exp(input logic [3:0] v);
        return ~((v[3] | v[2]) & (v[1] | v[0]));
    endfunction
endpackage

// File: rtl/oai22_seq_gen.sv
// oai22_seq_gen: 4-bit stimulus index with pass counting and binary/Gray vector mapping
module oai22_seq_gen
    import oai22_ex_pkg::*;
#(
    parameter int NUM_PASSES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    input  logic       mode,
    output logic [3:0] vec,
    output logic       last
);
    logic [3:0] idx;
    logic [3:0] idx_nx;
    logic [PASS_W-1:0] pass;
    logic gray;
    assign idx_nx = idx + 4'd1;
    assign last = (idx == 4'hf) && (pass == PASS_W'(NUM_PASSES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            pass <= '0;
            gray <= 1'b0;
            vec  <= '0;
        end else if (load) begin
            idx  <= '0;
            pass <= '0;
            gray <= mode;
            vec  <= '0;
        end else if (advance) begin
            idx  <= idx_nx;
            pass <= (idx == 4'hf) ? pass + PASS_W'(1) : pass;
            vec  <= gray ? (idx_nx ^ (idx_nx >> 1)) : idx_nx;
        end
    end
endmodule

// File: rtl/oai22_exerciser.sv
// oai22_exerciser: sweeps an OAI22 cell's input space and checks/counts its QN response
module oai22_exerciser
    import oai22_ex_pkg::*;
#(
    parameter int NUM_PASSES = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             START,
    input  logic             MODE,
    input  logic             QN,
    output logic             IN1,
    output logic             IN2,
    output logic             IN3,
    output logic             IN4,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [TOG_W-1:0] TOG_CNT
);
    // With no settle time each vector goes straight to its sample cycle
    localparam state_t FIRST = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
    state_t state, state_nx;
    logic [3:0] settle_cnt;
    logic [3:0] vec;
    logic last, accept, sampling, prev_qn, prev_vld;
    assign accept   = START && (state == ST_IDLE || state == ST_DONE);
    assign sampling = state == ST_SAMPLE;
    assign {IN1, IN2, IN3, IN4} = vec;
    assign BUSY = state == ST_SETTLE || state == ST_SAMPLE;
    assign DONE = state == ST_DONE;
    assign FAIL = DONE && (ERR_CNT != '0);

    oai22_seq_gen #(.NUM_PASSES(NUM_PASSES)) u_seq (
        .clk(CLK),
        .rst_n(RSTB),
        .load(accept),
        .advance(sampling && !last),
        .mode(MODE),
        .vec(vec),
        .last(last)
    );

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) state <= ST_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept) state_nx = FIRST;
        else if (state == ST_SETTLE && settle_cnt <= 4'd1) state_nx = ST_SAMPLE;
        else if (sampling) state_nx = last ? ST_DONE : FIRST;
    end

    // Loaded with SETTLE_CYC so SETTLE lasts exactly SETTLE_CYC cycles
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) settle_cnt <= '0;
        else if (accept || (sampling && !last)) settle_cnt <= 4'(SETTLE_CYC);
        else if (state == ST_SETTLE) settle_cnt <= settle_cnt - 4'd1;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            ERR_CNT  <= '0;
            TOG_CNT  <= '0;
            prev_qn  <= 1'b0;
            prev_vld <= 1'b0;
        end else if (accept) begin
            ERR_CNT  <= '0;
            TOG_CNT  <= '0;
            prev_qn  <= 1'b0;
            prev_vld <= 1'b0;
        end else if (sampling) begin
            if (QN != oai22_exp(vec) && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
            if (prev_vld && QN != prev_qn && TOG_CNT != '1) TOG_CNT <= TOG_CNT + 1'b1;
            prev_qn  <= QN;
            prev_vld <= 1'b1;
        end
    end
endmodule

// File: tb/tb_oai22_exerciser.sv
// tb_oai22_exerciser: table-driven runs plus hand sequences for ordering, reset, restart and saturation
module tb_oai22_exerciser;
    typedef struct {
        logic mode;
        int   qn_kind;
        int   err;
        int   tog;
        int   fail;
    } vec_t;

    logic CLK = 1'b0;
    logic RSTB = 1'b0;
    logic START = 1'b0;
    logic MODE = 1'b0;
    logic START32 = 1'b0;
    logic QN, IN1, IN2, IN3, IN4, BUSY, DONE, FAIL;
    logic [7:0] ERR_CNT;
    logic [15:0] TOG_CNT;
    logic B_IN1, B_IN2, B_IN3, B_IN4, B_BUSY, B_DONE, B_FAIL;
    logic [7:0] B_ERR;
    logic [15:0] B_TOG;
    logic gold;
    int qn_kind = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    oai22_exerciser dut (
        .CLK(CLK), .RSTB(RSTB), .START(START), .MODE(MODE), .QN(QN),
        .IN1(IN1), .IN2(IN2), .IN3(IN3), .IN4(IN4),
        .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .ERR_CNT(ERR_CNT), .TOG_CNT(TOG_CNT)
    );

    oai22_exerciser #(.NUM_PASSES(32), .SETTLE_CYC(0)) dut32 (
        .CLK(CLK), .RSTB(RSTB), .START(START32), .MODE(1'b0), .QN(1'b1),
        .IN1(B_IN1), .IN2(B_IN2), .IN3(B_IN3), .IN4(B_IN4),
        .BUSY(B_BUSY), .DONE(B_DONE), .FAIL(B_FAIL), .ERR_CNT(B_ERR), .TOG_CNT(B_TOG)
    );

    assign gold = ~((IN1 | IN2) & (IN3 | IN4));
    always_comb QN = (qn_kind == 0) ? gold : (qn_kind == 1) ? 1'b1 : (qn_kind == 2) ? 1'b0 : ~gold;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; a second START can be pulsed at cycle pulse_at to test it is ignored
    task automatic run(input logic mode, input int pulse_at, output int cyc);
        MODE = mode;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cyc = 0;
        while (!DONE && cyc < 2000) begin
            START = (cyc == pulse_at);
            MODE = (cyc == pulse_at) ? ~mode : mode;
            @(negedge CLK);
            cyc++;
        end
        START = 1'b0;
        MODE = mode;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in"}, int'({IN1, IN2, IN3, IN4}), 0);
        check({tag, "_busy"}, int'(BUSY), 0);
        check({tag, "_done"}, int'(DONE), 0);
        check({tag, "_fail"}, int'(FAIL), 0);
        check({tag, "_err"}, int'(ERR_CNT), 0);
        check({tag, "_tog"}, int'(TOG_CNT), 0);
    endtask

    initial begin
        vec_t tbl[6];
        int gray_ord[16];
        int cyc;
        tbl[0] = '{1'b0, 0, 0, 23, 0};
        tbl[1] = '{1'b1, 0, 0, 16, 0};
        tbl[2] = '{1'b0, 1, 36, 0, 1};
        tbl[3] = '{1'b0, 2, 28, 0, 1};
        tbl[4] = '{1'b0, 3, 64, 23, 1};
        tbl[5] = '{1'b1, 3, 64, 16, 1};
        gray_ord = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

        #3;
        check_all_zero("reset");
        @(negedge CLK);
        RSTB = 1'b1;
        @(negedge CLK);
        check("idle_busy", int'(BUSY), 0);

        for (int i = 0; i < 6; i++) begin
            qn_kind = tbl[i].qn_kind;
            run(tbl[i].mode, -1, cyc);
            check($sformatf("t%0d_cycles", i), cyc, 128);
            check($sformatf("t%0d_done", i), int'(DONE), 1);
            check($sformatf("t%0d_err", i), int'(ERR_CNT), tbl[i].err);
            check($sformatf("t%0d_tog", i), int'(TOG_CNT), tbl[i].tog);
            check($sformatf("t%0d_fail", i), int'(FAIL), tbl[i].fail);
        end

        // START in DONE restarts: counters clear and DONE drops on the next edge
        START = 1'b1;
        MODE = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("restart_done", int'(DONE), 0);
        check("restart_busy", int'(BUSY), 1);
        check("restart_err", int'(ERR_CNT), 0);
        check("restart_fail", int'(FAIL), 0);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("gray_v%0d", k), int'({IN1, IN2, IN3, IN4}), gray_ord[k]);
            repeat (2) @(negedge CLK);
        end
        cyc = 0;
        while (!DONE && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
        end
        check("gray_done", int'(DONE), 1);
        check("gray_err", int'(ERR_CNT), 64);

        // START pulsed while busy (with MODE flipped) must not disturb the run
        qn_kind = 0;
        run(1'b0, 20, cyc);
        check("busy_start_cycles", cyc, 128);
        check("busy_start_err", int'(ERR_CNT), 0);
        check("busy_start_tog", int'(TOG_CNT), 23);

        // Mid-run async reset at pass 2, vector 7
        MODE = 1'b0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (46) @(negedge CLK);
        check("mid_vec", int'({IN1, IN2, IN3, IN4}), 7);
        check("mid_tog", int'(TOG_CNT), 7);
        check("mid_busy", int'(BUSY), 1);
        #2 RSTB = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge CLK);
        RSTB = 1'b1;
        @(negedge CLK);
        check("post_rst_busy", int'(BUSY), 0);
        run(1'b0, -1, cyc);
        check("post_rst_cycles", cyc, 128);
        check("post_rst_err", int'(ERR_CNT), 0);
        check("post_rst_tog", int'(TOG_CNT), 23);

        // 32 passes against a stuck-high cell, no settle cycles: error count saturates
        START32 = 1'b1;
        @(negedge CLK);
        START32 = 1'b0;
        cyc = 0;
        while (!B_DONE && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
        end
        check("sat_cycles", cyc, 512);
        check("sat_err", int'(B_ERR), 255);
        check("sat_tog", int'(B_TOG), 0);
        check("sat_fail", int'(B_FAIL), 1);
        check("sat_busy", int'(B_BUSY), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
